// File: rtl/bus_output_register.sv
// Output (OI) register of the 8-bit computer: latches the bus on every active-low
// load strobe and queues each captured word in a small first-word-fall-through FIFO.
module bus_output_register #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           bus,
  input  logic                       load_n,
  output logic [WIDTH-1:0]           latched,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_latched;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A push into a full FIFO is still accepted when the head leaves at the same edge.
  assign w_push_req = ~load_n;
  assign w_pop      = (r_count != '0) && out_ready;
  assign w_push     = w_push_req && ((r_count != CW'(DEPTH)) || w_pop);
  assign w_drop     = w_push_req && !w_push;

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_latched  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_req) r_latched <= bus;
      if (w_push)     r_wr_ptr  <= r_wr_ptr + AW'(1);
      if (w_pop)      r_rd_ptr  <= r_rd_ptr + AW'(1);

      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);

      // Set wins over clear when a drop and a clear request coincide.
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  // NOTE: storage is not reset; its contents are only observable through
  // out_data while count is non-zero, and every such word was written first.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus;
  end

  assign latched   = r_latched;
  assign out_data  = r_mem[r_rd_ptr];
  assign out_valid = (r_count != '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_bus_output_register.sv
// Self-checking bench for bus_output_register: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_bus_output_register;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  bus;
  logic          load_n;
  logic [W-1:0]  latched;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic          clear_overflow;

  bus_output_register #(.WIDTH(W), .DEPTH(D)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .load_n         (load_n),
    .latched        (latched),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .full           (full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of words, the last captured value and the sticky flag.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_latched;
  logic         m_ovf;
  logic [W-1:0] m_popped[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".latched"},  32'(latched),   32'(m_latched));
    check({tag, ".count"},    32'(count),     32'(m_q.size()));
    check({tag, ".valid"},    32'(out_valid), 32'(m_q.size() != 0));
    check({tag, ".full"},     32'(full),      32'(m_q.size() == D));
    check({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
    if (m_q.size() != 0) check({tag, ".data"}, 32'(out_data), 32'(m_q[0]));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_popped.delete();
    m_latched = '0;
    m_ovf     = 1'b0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cycle(input string tag, input logic ld_n, input logic [W-1:0] b,
                       input logic rdy, input logic clr);
    logic dropped;
    load_n = ld_n; bus = b; out_ready = rdy; clear_overflow = clr;
    @(posedge clk);
    dropped = 1'b0;
    if (rdy && m_q.size() != 0) m_popped.push_back(m_q.pop_front());
    if (!ld_n) begin
      m_latched = b;
      if (m_q.size() < D) m_q.push_back(b);
      else dropped = 1'b1;
    end
    if (dropped)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    load_n = 1'b1; out_ready = 1'b0; clear_overflow = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_n = 1'b1; bus = '0; out_ready = 1'b0; clear_overflow = 1'b0;
    model_reset();
    #12;
    check_all("por");
    @(negedge clk);
    reset = 1'b0;

    // Single capture, then asynchronous reset mid-stream.
    cycle("cap1", 1'b0, 8'h2A, 1'b0, 1'b0);
    check("cap1.data_const", 32'(out_data), 32'h2A);
    apply_reset("rst_mid");
    check("rst_mid.latched0", 32'(latched), 32'h0);

    // Fill, overflow, clear-vs-set priority, then drain.
    for (int i = 1; i <= 4; i++) cycle("fill", 1'b0, W'(i), 1'b0, 1'b0);
    check("fill.full_const", 32'(full), 32'h1);
    cycle("ovf", 1'b0, 8'h05, 1'b0, 1'b0);
    check("ovf.flag_const", 32'(overflow), 32'h1);
    cycle("ovf_set_wins", 1'b0, 8'h06, 1'b0, 1'b1);
    cycle("ovf_clear", 1'b1, 8'h00, 1'b0, 1'b1);
    check("ovf_clear.const", 32'(overflow), 32'h0);
    for (int i = 0; i < 5; i++) cycle("drain1", 1'b1, 8'h00, 1'b1, 1'b0);
    check("drain1.n", 32'(m_popped.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("drain1.order", 32'(m_popped[i]), 32'(i + 1));

    // Full FIFO with simultaneous pop and push.
    apply_reset("rst2");
    for (int i = 1; i <= 4; i++) cycle("fill2", 1'b0, W'(i), 1'b0, 1'b0);
    cycle("swap", 1'b0, 8'h99, 1'b1, 1'b0);
    check("swap.ovf_const", 32'(overflow), 32'h0);
    for (int i = 0; i < 5; i++) cycle("drain2", 1'b1, 8'h00, 1'b1, 1'b0);

    // Empty FIFO, ready held high: no bypass.
    apply_reset("rst3");
    cycle("nobypass", 1'b0, 8'h10, 1'b1, 1'b0);
    check("nobypass.valid_const", 32'(out_valid), 32'h1);
    cycle("nobypass_pop", 1'b1, 8'h00, 1'b1, 1'b0);
    check("nobypass_pop.count_const", 32'(count), 32'h0);

    // Pointer wrap: ten words through with random ready, never dropping one.
    apply_reset("rst4");
    begin
      int idx = 0;
      int budget = 0;
      while ((idx < 10 || m_q.size() != 0) && budget < 200) begin
        logic rdy;
        logic push;
        rdy  = 1'($urandom_range(0, 1));
        push = (idx < 10) && (m_q.size() < D || (rdy && m_q.size() != 0));
        cycle("wrap", !push, W'(8'hA0 + idx), rdy, 1'b0);
        check("wrap.count_le", 32'(count <= CW'(D)), 32'h1);
        if (push) idx++;
        budget++;
      end
      check("wrap.done", 32'(budget < 200), 32'h1);
      check("wrap.n", 32'(m_popped.size()), 32'd10);
      for (int i = 0; i < m_popped.size(); i++) check("wrap.order", 32'(m_popped[i]), 32'(8'hA0 + i));
    end

    // Fully random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) apply_reset("rnd_rst");
      else cycle("rnd", 1'($urandom_range(0, 2) == 0), W'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_output_register.md
Name: bus_output_register

Overview:
- Bus reader for the 8-bit computer, the receiving end of the bus driver path: the output (OI) register.
- Captures the bus value on every clock edge where its active-low load strobe is asserted, and holds it as a 74LS173-style latched value.
- Also queues each captured word in a small FIFO, so a slower consumer (display multiplexer / UART debug tap) can drain values with a valid/ready handshake without missing back-to-back OUT instructions.

Parameters:
- WIDTH, 8, data width of bus and storage.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- bus  input  WIDTH  current bus value from the bus mux.
- load_n  input  1  active-low load strobe (OI control line).
- latched  output  WIDTH  last value captured from the bus.
- out_data  output  WIDTH  FIFO head word (first-word fall-through).
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  $clog2(DEPTH)+1  number of words held, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag: a capture was dropped.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, immediate, independent of clk):
  - latched=0, count=0, read/write pointers=0, overflow=0.
  - Hence out_valid=0, full=0. out_data is don't-care while out_valid=0; the bench checks it only when out_valid=1.
- Capture: at a rising edge with load_n==0, latched <= bus. This happens on every such edge, regardless of FIFO state. No edge detection: a strobe held low for k edges gives k captures.
- Push: a capture is a push request.
  - Accepted if count<DEPTH, or if count==DEPTH and a pop occurs at the same edge.
  - Otherwise dropped: FIFO unchanged, overflow <= 1.
- Pop: at a rising edge with out_valid==1 and out_ready==1.
  - out_ready while out_valid==0 is ignored; there is no underflow state.
- Push and pop at the same edge: both take effect and count is unchanged.
  - When count==0, the pushed word becomes the head after the edge. There is no bypass; out_valid rises one cycle after the push edge.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N. A pop at edge M shows the next word (or out_valid=0) after edge M.
- Combinational outputs: out_data = mem[rd_ptr], out_valid = (count!=0), full = (count==DEPTH). All are derived from registers only; there is no combinational path from inputs.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. count is tracked separately in a register.
- Overflow: sticky until reset or clear_overflow==1 at an edge. If clear_overflow and a dropped push coincide at the same edge, overflow ends at 1 (set wins).
- Reset asserted mid-stream discards all queued words. The first capture after reset release is treated as the first word.

Test Plan:
- Reset, then load_n low one edge with bus=0x2A, out_ready=0 -> latched=0x2A, count=1, out_valid=1, out_data=0x2A; reset mid-way again -> all outputs 0, out_valid=0.
- Four consecutive captures 0x01,0x02,0x03,0x04, out_ready=0 -> full=1, count=4. Fifth capture 0x05 -> latched=0x05, count=4, overflow=1. Then drain with out_ready=1 -> reads 0x01..0x04 in order, 0x05 absent.
- FIFO full, capture 0x99 with out_ready=1 at the same edge -> head 0x01 popped, 0x99 queued, count=4, overflow stays 0. Drain order 0x02,0x03,0x04,0x99.
- Empty FIFO, capture 0x10 with out_ready=1 held high -> out_valid=1 one cycle after the capture edge, popped at the next edge, count returns to 0.
- Wrap test: push/pop 10 words 0xA0..0xA9 with random out_ready -> output sequence identical to input, count never exceeds 4.
- overflow=1, assert clear_overflow together with a dropped push -> overflow=1. clear_overflow alone next edge -> overflow=0.
